// File: rtl/load_store_unit.sv
// load_store_unit: sequences byte/half/word loads and stores as single-byte memory accesses
module load_store_unit #(
   parameter int BUS_WIDTH  = 8,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   reqValid,
   output logic                   reqReady,
   input  logic                   reqWrite,
   input  logic [1:0]             reqSize,
   input  logic                   reqSigned,
   input  logic [ADDR_WIDTH-1:0]  reqAddr,
   input  logic [4*BUS_WIDTH-1:0] reqWData,
   output logic                   respValid,
   output logic [4*BUS_WIDTH-1:0] respRData,
   output logic [ADDR_WIDTH-1:0]  memAddress,
   output logic [BUS_WIDTH-1:0]   memWData,
   output logic                   memReadWriteControl,
   input  logic [BUS_WIDTH-1:0]   memRData
);
   localparam int W = 4*BUS_WIDTH;
   typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
   state_t                state_q, state_d;
   logic [1:0]            cnt_q, cnt_d, last_q, last_d;
   logic                  write_q, write_d, signed_q, signed_d;
   logic                  ready_q, ready_d, valid_q, valid_d, we_q, we_d;
   logic [W-1:0]          wdata_q, wdata_d, rdata_q, rdata_d, resp_q, resp_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [BUS_WIDTH-1:0]  wbyte_q, wbyte_d;
   // Next state: memory-side outputs are computed one cycle ahead so they are registered during each access
   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      write_d  = write_q;
      signed_d = signed_q;
      ready_d  = ready_q;
      valid_d  = 1'b0;
      we_d     = 1'b0;
      wdata_d  = wdata_q;
      rdata_d  = rdata_q;
      resp_d   = resp_q;
      addr_d   = addr_q;
      wbyte_d  = wbyte_q;
      case (state_q)
         IDLE: if (reqValid && ready_q) begin
            state_d  = ACCESS;
            cnt_d    = 2'd0;
            last_d   = reqSize == 2'b00 ? 2'd0 : reqSize == 2'b01 ? 2'd1 : 2'd3;
            write_d  = reqWrite;
            signed_d = reqSigned;
            ready_d  = 1'b0;
            we_d     = reqWrite;
            wdata_d  = reqWData;
            rdata_d  = '0;
            addr_d   = reqAddr;
            wbyte_d  = reqWData[BUS_WIDTH-1:0];
         end
         ACCESS: begin
            for (int i = 0; i < 4; i++)
               if (cnt_q == 2'(i)) rdata_d[i*BUS_WIDTH +: BUS_WIDTH] = memRData;
            if (cnt_q == last_q) begin
               state_d = DONE;
               valid_d = 1'b1;
               resp_d  = write_q ? '0
                       : last_q == 2'd0 ? {{(3*BUS_WIDTH){signed_q & rdata_d[BUS_WIDTH-1]}}, rdata_d[BUS_WIDTH-1:0]}
                       : last_q == 2'd1 ? {{(2*BUS_WIDTH){signed_q & rdata_d[2*BUS_WIDTH-1]}}, rdata_d[2*BUS_WIDTH-1:0]}
                       : rdata_d;
            end else begin
               cnt_d   = cnt_q + 2'd1;
               addr_d  = addr_q + ADDR_WIDTH'(1);
               wdata_d = wdata_q >> BUS_WIDTH;
               wbyte_d = wdata_q[2*BUS_WIDTH-1:BUS_WIDTH];
               we_d    = write_q;
            end
         end
         DONE: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
         default: begin
            state_d = IDLE;
            ready_d = 1'b1;
         end
      endcase
   end
   // State and output registers; reset aborts any request in flight
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         last_q   <= '0;
         write_q  <= 1'b0;
         signed_q <= 1'b0;
         ready_q  <= 1'b1;
         valid_q  <= 1'b0;
         we_q     <= 1'b0;
         wdata_q  <= '0;
         rdata_q  <= '0;
         resp_q   <= '0;
         addr_q   <= '0;
         wbyte_q  <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         last_q   <= last_d;
         write_q  <= write_d;
         signed_q <= signed_d;
         ready_q  <= ready_d;
         valid_q  <= valid_d;
         we_q     <= we_d;
         wdata_q  <= wdata_d;
         rdata_q  <= rdata_d;
         resp_q   <= resp_d;
         addr_q   <= addr_d;
         wbyte_q  <= wbyte_d;
      end
   end
   assign reqReady            = ready_q;
   assign respValid           = valid_q;
   assign respRData           = resp_q;
   assign memAddress          = addr_q;
   assign memWData            = wbyte_q;
   assign memReadWriteControl = we_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed table, corner sequences and randomized checks against a byte-array model
module tb_load_store_unit;
   logic        clk = 1'b0, rst = 1'b1;
   logic        reqValid = 1'b0, reqWrite = 1'b0, reqSigned = 1'b0;
   logic [1:0]  reqSize = 2'd0;
   logic [7:0]  reqAddr = 8'h00;
   logic [31:0] reqWData = 32'h0;
   logic        reqReady, respValid, memReadWriteControl;
   logic [31:0] respRData;
   logic [7:0]  memAddress, memWData, memRData;
   logic [7:0]  mem [256] = '{default: 8'h00};
   logic [7:0]  ref_mem [256];
   int          n_cmp = 0, n_fail = 0;

   load_store_unit #(.BUS_WIDTH(8), .ADDR_WIDTH(8)) dut (
      .clk(clk), .rst(rst), .reqValid(reqValid), .reqReady(reqReady), .reqWrite(reqWrite),
      .reqSize(reqSize), .reqSigned(reqSigned), .reqAddr(reqAddr), .reqWData(reqWData),
      .respValid(respValid), .respRData(respRData), .memAddress(memAddress), .memWData(memWData),
      .memReadWriteControl(memReadWriteControl), .memRData(memRData)
   );

   always #5 clk = ~clk;
   assign memRData = mem[memAddress];
   always @(posedge clk) if (memReadWriteControl) mem[memAddress] <= memWData;

   typedef struct {
      logic        w;
      logic [1:0]  sz;
      logic        sg;
      logic [7:0]  a;
      logic [31:0] wd;
      logic [31:0] exp;
      int          lat;
   } vec_t;
   vec_t tbl [11];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic int nbytes(input logic [1:0] sz);
      return sz == 2'd0 ? 1 : sz == 2'd1 ? 2 : 4;
   endfunction

   task automatic model(input logic w, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                        input logic [31:0] wd, output logic [31:0] exp);
      int n;
      logic [31:0] v;
      n = nbytes(sz);
      v = 32'h0;
      for (int i = 0; i < n; i++) begin
         if (w) ref_mem[8'(a + i)] = wd[8*i +: 8];
         else v[8*i +: 8] = ref_mem[8'(a + i)];
      end
      if (!w && sg && n < 4 && v[8*n-1]) v = v | ~((32'd1 << (8*n)) - 32'd1);
      exp = v;
   endtask

   task automatic do_req(input logic w, input logic [1:0] sz, input logic sg, input logic [7:0] a,
                         input logic [31:0] wd, output logic [31:0] rd, output int lat,
                         output int wr, output int bad, output logic rwc_done);
      int guard;
      guard = 0;
      while (!reqReady && guard < 20) begin
         @(posedge clk); #1;
         guard++;
      end
      reqValid = 1'b1; reqWrite = w; reqSize = sz; reqSigned = sg; reqAddr = a; reqWData = wd;
      @(posedge clk); #1;
      reqValid = 1'b0;
      lat = 1; wr = 0; bad = 0;
      while (!respValid && lat < 20) begin
         if (memReadWriteControl) wr++;
         if (lat <= nbytes(sz)) begin
            if (memAddress !== 8'(a + lat - 1)) bad++;
            if (memReadWriteControl && memWData !== wd[8*(lat-1) +: 8]) bad++;
         end
         @(posedge clk); #1;
         lat++;
      end
      rwc_done = memReadWriteControl;
      rd = respRData;
      if (!respValid) lat = 0;
   endtask

   task automatic run_and_check(input string name, input logic w, input logic [1:0] sz, input logic sg,
                                input logic [7:0] a, input logic [31:0] wd);
      logic [31:0] exp, rd;
      int lat, wr, bad, n;
      logic rwc;
      n = nbytes(sz);
      model(w, sz, sg, a, wd, exp);
      do_req(w, sz, sg, a, wd, rd, lat, wr, bad, rwc);
      check({name, "_rdata"}, rd, exp);
      check({name, "_latency"}, lat, n + 1);
      check({name, "_writes"}, wr, w ? n : 0);
      check({name, "_bus"}, bad, 0);
      check({name, "_rwc_done"}, rwc, 1'b0);
      @(posedge clk); #1;
      check({name, "_resp_pulse"}, respValid, 1'b0);
      check({name, "_ready_idle"}, reqReady, 1'b1);
   endtask

   initial begin
      logic [31:0] exp, rd;
      int lat, wr, bad, seen, diffs;
      logic rwc;
      for (int i = 0; i < 256; i++) ref_mem[i] = 8'h00;
      tbl[0]  = '{1'b1, 2'd2, 1'b0, 8'h10, 32'hDEADBEEF, 32'h00000000, 5};
      tbl[1]  = '{1'b0, 2'd2, 1'b0, 8'h10, 32'h0,        32'hDEADBEEF, 5};
      tbl[2]  = '{1'b1, 2'd0, 1'b0, 8'h20, 32'h00000080, 32'h00000000, 2};
      tbl[3]  = '{1'b0, 2'd0, 1'b1, 8'h20, 32'h0,        32'hFFFFFF80, 2};
      tbl[4]  = '{1'b0, 2'd0, 1'b0, 8'h20, 32'h0,        32'h00000080, 2};
      tbl[5]  = '{1'b1, 2'd1, 1'b0, 8'hFF, 32'h00001234, 32'h00000000, 3};
      tbl[6]  = '{1'b0, 2'd1, 1'b0, 8'hFF, 32'h0,        32'h00001234, 3};
      tbl[7]  = '{1'b0, 2'd3, 1'b1, 8'h10, 32'h0,        32'hDEADBEEF, 5};
      tbl[8]  = '{1'b0, 2'd1, 1'b1, 8'h12, 32'h0,        32'hFFFFDEAD, 3};
      tbl[9]  = '{1'b1, 2'd0, 1'b0, 8'h21, 32'h12345699, 32'h00000000, 2};
      tbl[10] = '{1'b0, 2'd0, 1'b1, 8'h21, 32'h0,        32'hFFFFFF99, 2};

      @(posedge clk); #1;
      @(posedge clk); #1;
      check("rst_ready", reqReady, 1'b1);
      check("rst_resp_valid", respValid, 1'b0);
      check("rst_resp_rdata", respRData, 32'h0);
      check("rst_mem_addr", memAddress, 8'h00);
      check("rst_mem_wdata", memWData, 8'h00);
      check("rst_rwc", memReadWriteControl, 1'b0);
      rst = 1'b0;
      @(posedge clk); #1;
      check("post_rst_ready", reqReady, 1'b1);

      for (int i = 0; i < 11; i++) begin
         model(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, exp);
         do_req(tbl[i].w, tbl[i].sz, tbl[i].sg, tbl[i].a, tbl[i].wd, rd, lat, wr, bad, rwc);
         check($sformatf("vec%0d_rdata", i), rd, tbl[i].exp);
         check($sformatf("vec%0d_latency", i), lat, tbl[i].lat);
         check($sformatf("vec%0d_rwc_done", i), rwc, 1'b0);
         @(posedge clk); #1;
         check($sformatf("vec%0d_resp_pulse", i), respValid, 1'b0);
      end
      check("mem_10", mem[8'h10], 8'hEF);
      check("mem_11", mem[8'h11], 8'hBE);
      check("mem_12", mem[8'h12], 8'hAD);
      check("mem_13", mem[8'h13], 8'hDE);
      check("mem_20", mem[8'h20], 8'h80);
      check("mem_21", mem[8'h21], 8'h99);
      check("mem_22", mem[8'h22], 8'h00);
      check("mem_ff", mem[8'hFF], 8'h34);
      check("mem_00", mem[8'h00], 8'h12);

      reqValid = 1'b1; reqWrite = 1'b0; reqSize = 2'd2; reqSigned = 1'b0; reqAddr = 8'h10;
      for (int c = 0; c < 13; c++) begin
         check($sformatf("b2b_ready_c%0d", c), reqReady, c % 6 == 0);
         check($sformatf("b2b_resp_c%0d", c), respValid, c % 6 == 5);
         if (c % 6 == 5) check($sformatf("b2b_rdata_c%0d", c), respRData, 32'hDEADBEEF);
         if (c == 11) reqValid = 1'b0;
         @(posedge clk); #1;
      end

      reqValid = 1'b1; reqWrite = 1'b1; reqSize = 2'd2; reqAddr = 8'h40; reqWData = 32'hAABBCCDD;
      @(posedge clk); #1;
      reqValid = 1'b0;
      @(posedge clk); #1;
      check("abort_rwc_before", memReadWriteControl, 1'b1);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort_rwc_after", memReadWriteControl, 1'b0);
      check("abort_ready", reqReady, 1'b1);
      check("abort_addr", memAddress, 8'h00);
      seen = 0;
      if (respValid) seen++;
      for (int c = 0; c < 8; c++) begin
         @(posedge clk); #1;
         if (respValid) seen++;
      end
      check("abort_no_resp", seen, 0);
      check("abort_mem_40", mem[8'h40], 8'hDD);
      check("abort_mem_42", mem[8'h42], 8'h00);
      check("abort_mem_43", mem[8'h43], 8'h00);
      ref_mem[8'h40] = 8'hDD;
      ref_mem[8'h41] = mem[8'h41];

      for (int t = 0; t < 80; t++) begin
         logic [7:0] a;
         a = ($urandom_range(0, 3) == 0) ? 8'(252 + $urandom_range(0, 3)) : 8'($urandom_range(0, 255));
         repeat ($urandom_range(0, 2)) begin
            @(posedge clk); #1;
         end
         run_and_check($sformatf("rnd%0d", t), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                       1'($urandom_range(0, 1)), a, $urandom);
      end
      diffs = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) diffs++;
      check("final_mem_diffs", diffs, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
